// File: rtl/lsu_wb_master.sv
// Wishbone B4 classic single-beat master behind the LSU: one bus cycle per request, one-cycle ack/err pulse back.
// Optional bus timeout enabled by defining LSU_WB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module lsu_wb_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_dat_i,
    input  logic [3:0]  lsu_sel_i,
    input  logic        lsu_we_i,
    input  logic        lsu_re_i,
    output logic [31:0] lsu_dat_o,
    output logic        lsu_ack_o,
    output logic        lsu_err_o,
    output logic        lsu_busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] adr_q, dat_q, rdata_q;
    logic [3:0]  sel_q;
    logic        we_q, err_q;
    logic        req, in_bus, timeout, bus_end, bus_err;

    assign req    = lsu_we_i | lsu_re_i;
    assign in_bus = (state == BUS);

`ifdef LSU_WB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counter sits at zero outside BUS, so it starts clean on every new access.
    assign timeout = in_bus && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_cnt <= '0;
        else if (!in_bus)
            tmo_cnt <= '0;
        else if (!(wb_ack_i | wb_err_i))
            tmo_cnt <= tmo_cnt + 16'd1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign timeout    = 1'b0;
`endif

    // A real ack beats a simultaneous timeout; a slave error beats everything.
    assign bus_end = wb_ack_i | wb_err_i | timeout;
    assign bus_err = wb_err_i | (timeout & ~wb_ack_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUS;
            BUS:     if (bus_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    adr_q <= lsu_addr_i;
                    dat_q <= lsu_dat_i;
                    sel_q <= lsu_sel_i;
                    we_q  <= lsu_we_i;
                end
                BUS: if (bus_end) begin
                    err_q <= bus_err;
                    if (!we_q && wb_ack_i && !wb_err_i)
                        rdata_q <= wb_dat_i;
                end
                default: ;
            endcase
        end
    end

    assign wb_cyc_o   = in_bus;
    assign wb_stb_o   = in_bus;
    assign wb_we_o    = in_bus & we_q;
    assign wb_adr_o   = adr_q;
    assign wb_sel_o   = sel_q;
    assign wb_dat_o   = (in_bus && we_q) ? dat_q : 32'h0;

    assign lsu_dat_o  = rdata_q;
    assign lsu_ack_o  = (state == DONE);
    assign lsu_err_o  = (state == DONE) & err_q;
    assign lsu_busy_o = (state != IDLE) | req;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Scoreboard bench for lsu_wb_master: directed requests against a configurable Wishbone slave model.
module tb_lsu_wb_master;

    logic        clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] lsu_addr = '0, lsu_dat = '0;
    logic [3:0]  lsu_sel = '0;
    logic        lsu_we = 1'b0, lsu_re = 1'b0;
    logic [31:0] lsu_dat_o;
    logic        lsu_ack_o, lsu_err_o, lsu_busy_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    lsu_wb_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_addr_i(lsu_addr), .lsu_dat_i(lsu_dat), .lsu_sel_i(lsu_sel),
        .lsu_we_i(lsu_we), .lsu_re_i(lsu_re),
        .lsu_dat_o(lsu_dat_o), .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o), .lsu_busy_o(lsu_busy_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // Slave: responds in stb cycle sl_ws+1 of a bus cycle, or never if both flags are low.
    int          sl_ws = 0;
    logic        sl_ack = 1'b0, sl_err = 1'b0;
    logic [31:0] sl_data = '0;
    int          stb_cnt = 0;
    always @(posedge clk) stb_cnt <= wb_stb_o ? stb_cnt + 1 : 0;
    assign wb_ack_i = wb_stb_o && (stb_cnt == sl_ws) && sl_ack;
    assign wb_err_i = wb_stb_o && (stb_cnt == sl_ws) && sl_err;
    assign wb_dat_i = sl_data;

    int          n_tests = 0, n_fail = 0;
    logic [32:0] sb[$];
    logic [68:0] exp_bus = '0;
    int          stb_seen = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response monitor: every lsu_ack_o must match the oldest expected response.
    always @(negedge clk) begin
        if (lsu_ack_o === 1'b1) begin
            if (sb.size() == 0)
                chk("unexpected_ack", 72'(lsu_ack_o), 72'(0));
            else
                chk("ack_resp", 72'({lsu_err_o, lsu_dat_o}), 72'(sb.pop_front()));
        end
    end

    // Bus monitor: request fields must hold steady for every strobe cycle.
    always @(negedge clk) begin
        if (wb_stb_o === 1'b1) begin
            stb_seen <= stb_seen + 1;
            chk("bus_fields", 72'({wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}),
                72'({1'b1, exp_bus}));
        end
    end

    task automatic issue(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int ws, input logic ack, input logic err,
                         input logic [31:0] sdat);
        @(posedge clk); #1;
        sl_ws = ws; sl_ack = ack; sl_err = err; sl_data = sdat;
        exp_bus  = {we, a, s, (we ? d : 32'h0)};
        stb_seen = 0;
        lsu_we = we; lsu_re = re; lsu_addr = a; lsu_dat = d; lsu_sel = s;
    endtask

    task automatic wait_ack(input string nm, input int exp_lat, input int exp_stb, input bit hold);
        int lat;
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (lsu_ack_o === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        chk({nm, "_latency"}, 72'(lat), 72'(exp_lat));
        chk({nm, "_stb_cycles"}, 72'(stb_seen), 72'(exp_stb));
        if (!hold) begin
            lsu_we = 1'b0;
            lsu_re = 1'b0;
        end
    endtask

    initial begin
        #2;
        chk("rst_cyc",  72'(wb_cyc_o), 72'(0));
        chk("rst_stb",  72'(wb_stb_o), 72'(0));
        chk("rst_bus",  72'({wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}), 72'(0));
        chk("rst_lsu",  72'({lsu_ack_o, lsu_err_o, lsu_busy_o, lsu_dat_o}), 72'(0));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Plain read, zero wait states.
        sb.push_back({1'b0, 32'hDEADBEEF});
        issue(1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hDEADBEEF);
        wait_ack("read", 2, 1, 1'b0);

        // Write with three wait states; read data must be untouched.
        sb.push_back({1'b0, 32'hDEADBEEF});
        issue(1'b1, 1'b0, 32'h204, 32'hABCDABCD, 4'b1100, 3, 1'b1, 1'b0, 32'h0);
        wait_ack("write", 5, 4, 1'b0);

        // ack and err together: error reported, data not latched.
        sb.push_back({1'b1, 32'hDEADBEEF});
        issue(1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 0, 1'b1, 1'b1, 32'h11111111);
        wait_ack("ack_err", 2, 1, 1'b0);

        // err alone after one wait state.
        sb.push_back({1'b1, 32'hDEADBEEF});
        issue(1'b0, 1'b1, 32'h304, 32'h0, 4'h1, 1, 1'b0, 1'b1, 32'h22222222);
        wait_ack("err_only", 3, 2, 1'b0);

        // we and re together -> write; request held past ack -> second access right after DONE.
        sb.push_back({1'b0, 32'hDEADBEEF});
        sb.push_back({1'b0, 32'hDEADBEEF});
        issue(1'b1, 1'b1, 32'h400, 32'h55AA55AA, 4'h3, 0, 1'b1, 1'b0, 32'h0);
        wait_ack("we_re", 2, 1, 1'b1);
        stb_seen = 0;
        wait_ack("held", 2, 1, 1'b0);

        // Read with two wait states updates the data register.
        sb.push_back({1'b0, 32'hCAFEF00D});
        issue(1'b0, 1'b1, 32'h208, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'hCAFEF00D);
        wait_ack("read_ws2", 4, 3, 1'b0);

        // Reset in the middle of a bus cycle: the access disappears without ack.
        issue(1'b0, 1'b1, 32'h600, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("pre_rst_stb", 72'(wb_stb_o), 72'(1));
        rst = 1'b1;
        lsu_re = 1'b0;
        #1;
        chk("mid_rst_cyc_stb", 72'({wb_cyc_o, wb_stb_o}), 72'(0));
        chk("mid_rst_lsu", 72'({lsu_ack_o, lsu_busy_o, lsu_dat_o}), 72'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 72'({lsu_busy_o, wb_cyc_o}), 72'(0));

        sb.push_back({1'b0, 32'h12345678});
        issue(1'b0, 1'b1, 32'h500, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h12345678);
        wait_ack("post_rst_read", 3, 2, 1'b0);

`ifdef LSU_WB_TIMEOUT_EN
        // Silent slave: abort after TIMEOUT_CYCLES strobe cycles with error.
        sb.push_back({1'b1, 32'h12345678});
        issue(1'b0, 1'b1, 32'h700, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0);
        wait_ack("timeout", 5, 4, 1'b0);

        // Ack on the limit cycle wins over the timeout.
        sb.push_back({1'b0, 32'h0BADCAFE});
        issue(1'b0, 1'b1, 32'h704, 32'h0, 4'hF, 3, 1'b1, 1'b0, 32'h0BADCAFE);
        wait_ack("ack_at_limit", 5, 4, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 72'(sb.size()), 72'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
